alu_lane_pipe: RTL and testbench

- Multi-lane ALU array with a 2-stage valid/ready pipeline.
- Generalises the fixed 6-lane, 4-bit combinational interface ALU array to parametrised lane count and operand width.
- Widens the opcode to 3 bits and adds a per-lane accumulator mode.
- Sits between a packed request bus and a packed result bus. Lane packing is unchanged from the existing array, so the current 6-lane/4-bit cosim is a subset of its behaviour.

---
 rtl/alu_lane_pkg.sv | 27 ++
 rtl/alu_lane_core.sv | 50 +++++
 rtl/alu_lane_pipe.sv | 73 +++++++
 tb/tb_alu_lane_pipe.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_lane_pkg.sv
// Shared opcode encoding and lane field widths for the ALU lane pipeline.
package alu_lane_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_ACC  = 3'd5,
    OP_CLR  = 3'd6,
    OP_PASS = 3'd7
  } op_t;

  // Packed request lane: {a, b, op}
  function automatic int unsigned LANE_IN_W(input int unsigned w);
    return 2 * w + OP_W;
  endfunction

  // Result lane carries one extra bit for carry/borrow
  function automatic int unsigned LANE_OUT_W(input int unsigned w);
    return w + 1;
  endfunction

endpackage

// File: rtl/alu_lane_core.sv
// One ALU lane: combinational result plus an accumulator that commits on adv.
module alu_lane_core
  import alu_lane_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            adv,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic [OP_W-1:0] op,
  output logic [W:0]      r
);

  logic [W:0] acc;
  logic [W:0] a_z;
  logic [W:0] b_z;

  assign a_z = {1'b0, a};
  assign b_z = {1'b0, b};

  always_comb begin
    r = '0;
    case (op_t'(op))
      OP_ADD:  r = a_z + b_z;
      OP_SUB:  r = a_z - b_z;
      OP_AND:  r = a_z & b_z;
      OP_OR:   r = a_z | b_z;
      OP_XOR:  r = a_z ^ b_z;
      OP_ACC:  r = acc + a_z;
      OP_CLR:  r = '0;
      OP_PASS: r = a_z;
    endcase
  end

  // Commit only when the request actually leaves S1 so stalls never double-count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (adv) begin
      if (op == OP_ACC) begin
        acc <= r;
      end else if (op == OP_CLR) begin
        acc <= '0;
      end
    end
  end

endmodule

// File: rtl/alu_lane_pipe.sv
// Multi-lane ALU array behind a two-stage valid/ready pipeline.
module alu_lane_pipe
  import alu_lane_pkg::*;
#(
  parameter int unsigned LANES = 6,
  parameter int unsigned W     = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [LANES*LANE_IN_W(W)-1:0]      in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [LANES*LANE_OUT_W(W)-1:0]     out_data
);

  localparam int unsigned LIN  = LANE_IN_W(W);
  localparam int unsigned LOUT = LANE_OUT_W(W);

  logic                  s1_valid;
  logic                  s2_valid;
  logic [LANES*LIN-1:0]  s1_data;
  logic [LANES*LOUT-1:0] res_c;
  logic                  s2_free;
  logic                  adv;
  logic                  in_xfer;

  assign s2_free   = !s2_valid || out_ready;
  assign adv       = s1_valid && s2_free;
  assign in_ready  = !s1_valid || s2_free;
  assign in_xfer   = in_valid && in_ready;
  assign out_valid = s2_valid;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    alu_lane_core #(.W(W)) u_core (
      .clk   (clk),
      .rst_n (rst_n),
      .adv   (adv),
      .a     (s1_data[i*LIN + OP_W + W +: W]),
      .b     (s1_data[i*LIN + OP_W +: W]),
      .op    (s1_data[i*LIN +: OP_W]),
      .r     (res_c[i*LOUT +: LOUT])
    );
  end

  // S1 holds raw lane fields; refills in the same cycle it drains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
      s1_data  <= in_data;
    end else if (adv) begin
      s1_valid <= 1'b0;
    end
  end

  // S2 holds computed results; out_data frozen while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_data <= '0;
    end else if (adv) begin
      s2_valid <= 1'b1;
      out_data <= res_c;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_lane_pipe.sv
// Scoreboard bench for alu_lane_pipe against a spec-level lane model.
module tb_alu_lane_pipe;
  import alu_lane_pkg::*;

  localparam int LANES = 6;
  localparam int W     = 4;
  localparam int LIN   = 2*W + 3;
  localparam int LOUT  = W + 1;
  localparam int IN_W  = LANES*LIN;
  localparam int OUT_W = LANES*LOUT;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [IN_W-1:0]  in_data;
  logic [OUT_W-1:0] out_data;

  logic             in_valid2, in_ready2, out_valid2, out_ready2;
  logic [18:0]      in_data2;
  logic [8:0]       out_data2;

  always #5 clk = ~clk;

  alu_lane_pipe #(.LANES(LANES), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
  );

  alu_lane_pipe #(.LANES(1), .W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_data(out_data2)
  );

  int tests = 0;
  int fails = 0;
  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] seen[$];
  int macc[LANES];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: each lane applies the opcode rules with integer arithmetic mod 2^(W+1)
  function automatic logic [OUT_W-1:0] model(input logic [IN_W-1:0] d);
    logic [OUT_W-1:0] e;
    int m;
    e = '0;
    m = 1 << (W+1);
    for (int i = 0; i < LANES; i++) begin
      int a, b, op, r;
      a  = int'(d[i*LIN+3+W +: W]);
      b  = int'(d[i*LIN+3 +: W]);
      op = int'(d[i*LIN +: 3]);
      case (op)
        0: r = (a + b) % m;
        1: r = (a - b + m) % m;
        2: r = a & b;
        3: r = a | b;
        4: r = a ^ b;
        5: begin macc[i] = (macc[i] + a) % m; r = macc[i]; end
        6: begin macc[i] = 0; r = 0; end
        default: r = a;
      endcase
      e[i*LOUT +: LOUT] = LOUT'(r);
    end
    return e;
  endfunction

  function automatic logic [IN_W-1:0] set_lane(input logic [IN_W-1:0] v, input int i,
                                               input int a, input int b, input int op);
    v[i*LIN +: LIN] = {W'(a), W'(b), 3'(op)};
    return v;
  endfunction

  function automatic logic [IN_W-1:0] base();
    logic [IN_W-1:0] v;
    v = '0;
    for (int i = 0; i < LANES; i++) v = set_lane(v, i, 0, 0, 7);
    return v;
  endfunction

  function automatic logic [63:0] lane_of(input logic [OUT_W-1:0] v, input int i);
    return 64'(v[i*LOUT +: LOUT]);
  endfunction

  // Scoreboard push on every accepted request
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) exp_q.push_back(model(in_data));
  end

  // Monitor: pop and compare on every output transfer
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      seen.push_back(out_data);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got %0h expected none", out_data);
      end else begin
        chk("out_data", 64'(out_data), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic send(input logic [IN_W-1:0] d);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 64 cycles");
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [IN_W-1:0] d;
    int n0;
    bit done;
    logic [8:0] exp8[4];
    int ops8[4];

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // ADD / SUB latency and single-cycle valid
    d = set_lane(base(), 0, 9, 8, 0);
    d = set_lane(d, 1, 3, 5, 1);
    send(d);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("lat_out_valid", 64'(out_valid), 64'd1);
    chk("add_lane0", lane_of(out_data, 0), 64'h11);
    chk("sub_lane1", lane_of(out_data, 1), 64'h1E);
    @(posedge clk); #1;
    chk("valid_one_cycle", 64'(out_valid), 64'd0);

    // Backpressure: two accepted then in_ready drops
    seen.delete();
    out_ready = 1'b0;
    send(set_lane(base(), 0, 1, 0, 7));
    send(set_lane(base(), 0, 2, 0, 7));
    in_data = set_lane(base(), 0, 3, 0, 7);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    fork
      send(set_lane(base(), 0, 3, 0, 7));
      begin repeat (2) @(posedge clk); #1 out_ready = 1'b1; end
    join
    idle(4);
    chk("bp_count", 64'(seen.size()), 64'd3);
    for (int i = 0; i < 3 && i < seen.size(); i++)
      chk("bp_order", lane_of(seen[i], 0), 64'(i+1));

    // Lane2 accumulator chain with wrap and clear
    seen.delete();
    send(set_lane(base(), 2, 15, 0, 5));
    send(set_lane(base(), 2, 15, 0, 5));
    send(set_lane(base(), 2, 7, 0, 5));
    send(set_lane(base(), 2, 0, 0, 6));
    send(set_lane(base(), 2, 1, 0, 5));
    idle(4);
    chk("acc_count", 64'(seen.size()), 64'd5);
    if (seen.size() == 5) begin
      chk("acc_0", lane_of(seen[0], 2), 64'd15);
      chk("acc_1", lane_of(seen[1], 2), 64'd30);
      chk("acc_wrap", lane_of(seen[2], 2), 64'd5);
      chk("acc_clr", lane_of(seen[3], 2), 64'd0);
      chk("acc_after_clr", lane_of(seen[4], 2), 64'd1);
    end

    // Accumulator held in stalled S1 commits once
    seen.delete();
    out_ready = 1'b0;
    send(set_lane(base(), 0, 9, 0, 7));
    send(set_lane(base(), 3, 4, 0, 5));
    idle(3);
    out_ready = 1'b1;
    send(set_lane(base(), 3, 4, 0, 5));
    idle(4);
    chk("stall_count", 64'(seen.size()), 64'd3);
    if (seen.size() == 3) begin
      chk("stall_acc_first", lane_of(seen[1], 3), 64'd4);
      chk("stall_acc_second", lane_of(seen[2], 3), 64'd8);
    end

    // Reset with two requests in flight
    send(set_lane(base(), 0, 5, 0, 5));
    send(set_lane(base(), 0, 6, 0, 5));
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_data", 64'(out_data), 64'd0);
    exp_q.delete();
    for (int i = 0; i < LANES; i++) macc[i] = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_in_ready", 64'(in_ready), 64'd1);
    seen.delete();
    send(set_lane(base(), 0, 2, 0, 5));
    idle(4);
    chk("postrst_count", 64'(seen.size()), 64'd1);
    if (seen.size() == 1) chk("postrst_acc", lane_of(seen[0], 0), 64'd2);

    // One 8-bit lane: bitwise and pass
    ops8 = '{2, 3, 4, 7};
    exp8 = '{9'h024, 9'h0BD, 9'h099, 9'h0A5};
    for (int k = 0; k < 4; k++) begin
      chk("w8_in_ready", 64'(in_ready2), 64'd1);
      in_valid2 = 1'b1;
      in_data2  = {8'hA5, 8'h3C, 3'(ops8[k])};
      @(posedge clk); #1;
      in_valid2 = 1'b0;
      @(posedge clk); #1;
      chk("w8_out_valid", 64'(out_valid2), 64'd1);
      chk("w8_result", 64'(out_data2), 64'(exp8[k]));
    end

    // Randomized traffic with random backpressure
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          logic [IN_W-1:0] r;
          r = '0;
          for (int i = 0; i < LANES; i++)
            r = set_lane(r, i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                         int'($urandom_range(0, 7)));
          if ($urandom_range(0, 3) == 0) idle(1);
          send(r);
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    out_ready = 1'b1;
    n0 = 0;
    while (exp_q.size() != 0 && n0 < 100) begin
      @(posedge clk);
      n0++;
    end
    #1;
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
